frame_rsp_collector: RTL and testbench
======================================

// Module: frame_rsp_collector
// PURPOSE
//  Return path of the switch-instance frame interface. Collects per-instance responses
//  (addr, data, rd/wr flag, op_id) from NUM_SW_INST switch instances.
//  Arbitrates round-robin, packs each response into a FRAME_WIDTH frame in the same field
//  layout as the request frame, and buffers it in a small FIFO. The frame is drained over a
//  valid/ready handshake towards the frame source.
// PARAMETERS
//  NUM_SW_INST  5   number of switch instances; 1..32
//  W_WIDTH      8   response data width; must be <= 8, zero-extended into frame[15:8]
//  FRAME_WIDTH  32  output frame width; fixed at 32
//  FIFO_DEPTH   4   output frame buffer entries; power of 2, >= 2
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst          in   1                  reset, synchronous, active-high
//  rsp_valid    in   NUM_SW_INST        per-instance response valid
//  rsp_ready    out  NUM_SW_INST        per-instance accept (one-hot grant or 0)
//  rsp_addr     in   NUM_SW_INST*8      packed addr, instance i at [8i+7:8i]
//  rsp_data     in   NUM_SW_INST*W_WIDTH  packed read data / write echo
//  rsp_wr_rd_s  in   NUM_SW_INST        packed rd/wr flag echo
//  rsp_op_id    in   NUM_SW_INST*8      packed op_id echo
//  frame_out    out  FRAME_WIDTH        head-of-FIFO frame
//  frame_valid  out  1                  frame_out valid (FIFO not empty)
//  frame_ready  in   1                  consumer accepts frame_out
//  fifo_count   out  clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, wr_ptr=rd_ptr=0, rr_ptr=0, frame_valid=0,
//    frame_out=0, fifo_count=0. rsp_ready=0 while rst=1. Reset mid-transfer discards all
//    buffered frames. An in-flight accept in the reset cycle is dropped.
//  - Frame layout: [31:27] source instance index, [26:22] 0, [21:17] addr[4:0],
//    [16] wr_rd_s, [15:8] {zero-ext data}, [7:0] op_id. addr[7:5] is ignored.
//  - Arbiter (combinational): if count < FIFO_DEPTH, grant the first i with rsp_valid[i]=1,
//    searching from rr_ptr upward with wrap at NUM_SW_INST-1 -> 0. rsp_ready = onehot(i).
//    If full or no request: rsp_ready=0.
//  - Accept = rsp_valid[i] & rsp_ready[i]. At that posedge, push the packed frame at wr_ptr
//    and set rr_ptr = (i==NUM_SW_INST-1) ? 0 : i+1. rr_ptr holds when nothing is accepted.
//  - At most one push per cycle. A full FIFO blocks grants even if a pop occurs in the same
//    cycle; there is no pass-through.
//  - Pop = frame_valid & frame_ready: rd_ptr advances at the posedge. frame_out is always the
//    entry at rd_ptr, driven from registers. frame_valid = (count != 0).
//  - Simultaneous push and pop: count unchanged, both pointers advance, and pointers wrap
//    modulo FIFO_DEPTH.
//  - Latency: response accepted at edge N appears on frame_out/frame_valid after edge N if
//    the FIFO was empty. Otherwise it appears in FIFO order.
//  - frame_ready while frame_valid=0 has no effect; count never underflows.
//  - Responses are never dropped. An instance holds rsp_valid and its fields stable until
//    accepted (instance-side rule; the bench checks it).
//  - op_id ordering per instance is preserved; across instances, order is the grant order.
// TESTING
//  1 single rsp: inst 2 valid, addr=0x13, data=0xA5, wr_rd_s=0, op_id=0x42, frame_ready=1
//    -> rsp_ready[2]=1 same cycle; next cycle frame_valid=1, frame_out=0x1026A542.
//  2 all 5 valid continuously, frame_ready=1 -> grants in order 0,1,2,3,4,0,...; frame
//    source fields match and rr_ptr wraps 4->0.
//  3 backpressure: frame_ready=0, 5 instances valid -> 4 accepted, fifo_count=4,
//    rsp_ready=0; raise frame_ready -> one pop/cycle, 5th accepted the cycle after count<4.
//  4 simultaneous push and pop at count=2 -> count stays 2, frame order preserved across
//    pointer wrap.
//  5 rst=1 with count=3 mid-drain -> next cycle frame_valid=0, fifo_count=0, frame_out=0,
//    rsp_ready=0; after release, next grant starts at inst 0.
//  6 frame_ready=1 with FIFO empty -> no state change, fifo_count stays 0.

Source files
------------

// File: rtl/frame_rsp_collector.sv
// Return path of the switch-instance frame interface: round-robin collection of
// per-instance responses, packed into request-layout frames and buffered for the frame source.
module frame_rsp_collector #(
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned FRAME_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SW_INST-1:0]            rsp_valid,
    output logic [NUM_SW_INST-1:0]            rsp_ready,
    input  logic [NUM_SW_INST*8-1:0]          rsp_addr,
    input  logic [NUM_SW_INST*W_WIDTH-1:0]    rsp_data,
    input  logic [NUM_SW_INST-1:0]            rsp_wr_rd_s,
    input  logic [NUM_SW_INST*8-1:0]          rsp_op_id,
    output logic [FRAME_WIDTH-1:0]            frame_out,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;

    logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_SW_INST-1:0] grant_c;
    logic [IDX_W-1:0]       gnt_idx_c;
    logic [FRAME_WIDTH-1:0] frame_c;
    logic                   push_c;
    logic                   pop_c;
    int                     j;

    // Round-robin search from rr_ptr; a full FIFO blocks all grants regardless of a pop.
    always_comb begin
        grant_c   = '0;
        gnt_idx_c = rr_ptr_q;
        frame_c   = '0;
        push_c    = 1'b0;
        j         = 0;
        if (!rst && (count_q < CNT_W'(FIFO_DEPTH))) begin
            for (int k = 0; k < int'(NUM_SW_INST); k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= int'(NUM_SW_INST)) begin
                    j = j - int'(NUM_SW_INST);
                end
                if (!push_c && rsp_valid[j]) begin
                    push_c     = 1'b1;
                    grant_c[j] = 1'b1;
                    gnt_idx_c  = IDX_W'(j);
                    frame_c    = FRAME_WIDTH'({5'(j), 5'b0, rsp_addr[j*8 +: 5], rsp_wr_rd_s[j],
                                               8'(rsp_data[j*W_WIDTH +: W_WIDTH]),
                                               rsp_op_id[j*8 +: 8]});
                end
            end
        end
    end

    always_comb begin
        pop_c    = (count_q != '0) && frame_ready;
        wr_ptr_d = push_c ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rr_ptr_d = rr_ptr_q;
        if (push_c) begin
            rr_ptr_d = (gnt_idx_c == IDX_W'(NUM_SW_INST - 1)) ? '0 : gnt_idx_c + 1'b1;
        end
    end

    // Storage is cleared on reset so frame_out reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= frame_c;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_ready   = grant_c;
    assign frame_out   = mem_q[rd_ptr_q];
    assign frame_valid = (count_q != '0);
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_frame_rsp_collector.sv
// Directed bench for frame_rsp_collector: arbitration order, frame packing, backpressure,
// pointer wrap and reset behaviour against hand-derived frames.
module tb_frame_rsp_collector;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 8;
    localparam int unsigned FW = 32;
    localparam int unsigned D  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [N*8-1:0]    rsp_addr;
    logic [N*W-1:0]    rsp_data;
    logic [N-1:0]      rsp_wr_rd_s;
    logic [N*8-1:0]    rsp_op_id;
    logic [FW-1:0]     frame_out;
    logic              frame_valid;
    logic              frame_ready;
    logic [2:0]        fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] a_t [N];
    logic [7:0] d_t [N];
    logic       w_t [N];
    logic [7:0] o_t [N];

    always #5 clk = ~clk;

    frame_rsp_collector #(
        .NUM_SW_INST(N), .W_WIDTH(W), .FRAME_WIDTH(FW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_wr_rd_s(rsp_wr_rd_s), .rsp_op_id(rsp_op_id),
        .frame_out(frame_out), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .fifo_count(fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int i, input logic [7:0] a, input logic [7:0] d,
                                       input logic w, input logic [7:0] op);
        return {5'(i), 5'b0, a[4:0], w, d, op};
    endfunction

    function automatic logic [31:0] exp_inst(input int i);
        return mk(i, a_t[i], d_t[i], w_t[i], o_t[i]);
    endfunction

    task automatic set_inst(input int i, input logic [7:0] a, input logic [7:0] d,
                            input logic w, input logic [7:0] op);
        rsp_addr[i*8 +: 8]  = a;
        rsp_data[i*W +: W]  = d;
        rsp_wr_rd_s[i]      = w;
        rsp_op_id[i*8 +: 8] = op;
    endtask

    task automatic load_all();
        for (int i = 0; i < int'(N); i++) set_inst(i, a_t[i], d_t[i], w_t[i], o_t[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            a_t[i] = 8'hE0 | 8'(i * 3);
            d_t[i] = 8'(8'h31 + i * 8'h17);
            w_t[i] = i[0];
            o_t[i] = 8'(8'h80 + i);
        end
        rst = 1'b1; rsp_valid = '0; rsp_addr = '0; rsp_data = '0;
        rsp_wr_rd_s = '0; rsp_op_id = '0; frame_ready = 1'b0;
        step(); step();

        // Reset state
        check("rst_ready", 32'(rsp_ready), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_frame", frame_out, 32'h0);

        // 1: single response from instance 2
        rst = 1'b0;
        set_inst(2, 8'h13, 8'hA5, 1'b0, 8'h42);
        rsp_valid = 5'b00100; frame_ready = 1'b1;
        #1 check("t1_ready", 32'(rsp_ready), 32'h4);
        step(); rsp_valid = '0;
        check("t1_valid", 32'(frame_valid), 32'h1);
        check("t1_frame", frame_out, 32'h1026A542);
        check("t1_count", 32'(fifo_count), 32'h1);
        step();
        check("t1_drain", 32'(fifo_count), 32'h0);

        // 2: all instances valid, continuous drain, rr wraps 4->0
        do_reset(); load_all(); rsp_valid = '1; frame_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 check($sformatf("t2_grant%0d", c), 32'(rsp_ready), 32'(1 << (c % 5)));
            step();
            check($sformatf("t2_frame%0d", c), frame_out, exp_inst(c % 5));
            check($sformatf("t2_count%0d", c), 32'(fifo_count), 32'h1);
        end
        rsp_valid = '0; step();
        check("t2_drain", 32'(fifo_count), 32'h0);

        // 3: backpressure fills the FIFO, 5th accepted once a slot frees
        do_reset(); load_all(); frame_ready = 1'b0; rsp_valid = '1;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("t3_grant%0d", c), 32'(rsp_ready), 32'(1 << c));
            step(); rsp_valid[c] = 1'b0;
        end
        check("t3_full", 32'(fifo_count), 32'h4);
        #1 check("t3_blocked", 32'(rsp_ready), 32'h0);
        frame_ready = 1'b1;
        #1 check("t3_full_pop_blocks", 32'(rsp_ready), 32'h0);
        step();
        check("t3_cnt3", 32'(fifo_count), 32'h3);
        check("t3_head1", frame_out, exp_inst(1));
        #1 check("t3_grant4", 32'(rsp_ready), 32'h10);
        step(); rsp_valid = '0;
        check("t3_pushpop", 32'(fifo_count), 32'h3);
        check("t3_head2", frame_out, exp_inst(2));
        step(); check("t3_head3", frame_out, exp_inst(3));
        step(); check("t3_head4", frame_out, exp_inst(4));
        check("t3_cnt1", 32'(fifo_count), 32'h1);
        step(); check("t3_empty", 32'(frame_valid), 32'h0);

        // 4: push+pop at count 2 across pointer wrap
        frame_ready = 1'b0; rsp_valid = 5'b00001;
        #1 check("t4_grant0", 32'(rsp_ready), 32'h1);
        step(); rsp_valid = 5'b00010;
        step(); rsp_valid = '0;
        check("t4_cnt2", 32'(fifo_count), 32'h2);
        check("t4_head0", frame_out, exp_inst(0));
        frame_ready = 1'b1; rsp_valid = 5'b00100;
        #1 check("t4_grant2", 32'(rsp_ready), 32'h4);
        step(); rsp_valid = 5'b01000;
        check("t4_pp1_cnt", 32'(fifo_count), 32'h2);
        check("t4_pp1_head", frame_out, exp_inst(1));
        step(); rsp_valid = '0;
        check("t4_pp2_cnt", 32'(fifo_count), 32'h2);
        check("t4_pp2_head", frame_out, exp_inst(2));
        step(); check("t4_head3", frame_out, exp_inst(3));
        check("t4_cnt1", 32'(fifo_count), 32'h1);
        step(); check("t4_empty", 32'(fifo_count), 32'h0);

        // 5: reset mid-drain with 3 buffered frames
        frame_ready = 1'b0; rsp_valid = '1;
        step(); rsp_valid[4] = 1'b0;
        step(); rsp_valid[0] = 1'b0;
        step(); rsp_valid[1] = 1'b0;
        check("t5_cnt3", 32'(fifo_count), 32'h3);
        frame_ready = 1'b1; rst = 1'b1;
        #1 check("t5_ready_in_rst", 32'(rsp_ready), 32'h0);
        step();
        check("t5_valid", 32'(frame_valid), 32'h0);
        check("t5_count", 32'(fifo_count), 32'h0);
        check("t5_frame", frame_out, 32'h0);
        check("t5_ready", 32'(rsp_ready), 32'h0);
        rst = 1'b0; rsp_valid = '1;
        #1 check("t5_rr_restart", 32'(rsp_ready), 32'h1);
        rsp_valid = '0;

        // 6: frame_ready with an empty FIFO changes nothing
        frame_ready = 1'b1;
        step(); step(); step();
        check("t6_count", 32'(fifo_count), 32'h0);
        check("t6_valid", 32'(frame_valid), 32'h0);
        check("t6_frame", frame_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
